// File: rtl/apb_read_responder.sv
// -----------------------------------------------------------------------------
// apb_read_responder
//
// APB completer serving CPU reads from the sensor-fusion register table.
// A read setup phase is decoded; legal addresses fetch a word from the table
// over a one-cycle req / valid side port, and the word is returned with wait
// states. Misaligned or out-of-range addresses, and fetches that exceed
// TIMEOUT cycles, complete with PSLVERR. Write transfers are ignored.
//
// Optional feature (macro RD_ERR_CNT_EN): adds output rd_err_count, a
// saturating 8-bit count of error responses.
//
// Ports
//   PCLK, PRESETn        clock (posedge) and asynchronous active-low reset
//   PSEL, PENABLE,       APB request signals
//   PWRITE, PADDR
//   PRDATA, PREADY,      APB response, all decoded from registered state
//   PSLVERR
//   rd_err_count         error-response counter (RD_ERR_CNT_EN only)
//   reg_rd_req           one-cycle fetch strobe to the register table
//   reg_rd_idx           register index being fetched
//   reg_rd_valid,        table response; only looked at while fetching
//   reg_rd_data
// -----------------------------------------------------------------------------
module apb_read_responder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          NUM_REGS  = 16,
  parameter int          TIMEOUT   = 10
) (
  input  logic                        PCLK,
  input  logic                        PRESETn,
  input  logic                        PSEL,
  input  logic                        PENABLE,
  input  logic                        PWRITE,
  input  logic [31:0]                 PADDR,
  output logic [31:0]                 PRDATA,
  output logic                        PREADY,
  output logic                        PSLVERR,
`ifdef RD_ERR_CNT_EN
  output logic [7:0]                  rd_err_count,
`endif
  output logic                        reg_rd_req,
  output logic [$clog2(NUM_REGS)-1:0] reg_rd_idx,
  input  logic                        reg_rd_valid,
  input  logic [31:0]                 reg_rd_data
);

  localparam int          IDX_W     = $clog2(NUM_REGS);
  localparam logic [31:0] SPAN      = 32'(4 * NUM_REGS);
  localparam logic [7:0]  TIMEOUT_C = 8'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [31:0]        data_q, data_d;
  logic               err_q, err_d;

  logic [31:0]        offset;
  logic               addr_legal;
  logic               setup_seen;
  logic [7:0]         cnt_inc;

  // PADDR >= BASE_ADDR is tested first so the subtraction below cannot wrap
  // into a falsely small offset.
  assign offset     = PADDR - BASE_ADDR;
  assign addr_legal = (PADDR[1:0] == 2'b00) && (PADDR >= BASE_ADDR) && (offset < SPAN);
  assign setup_seen = PSEL && !PENABLE && !PWRITE;
  assign cnt_inc    = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    data_d  = data_q;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (setup_seen) begin
          cnt_d  = 8'd0;
          data_d = 32'd0;
          if (addr_legal) begin
            idx_d   = offset[IDX_W+1:2];
            err_d   = 1'b0;
            state_d = REQ;
          end else begin
            err_d   = 1'b1;
            state_d = RESP;
          end
        end
      end

      REQ, WAIT: begin
        if (!PSEL) begin
          // Master abandoned the transfer: drop it without a response.
          state_d = IDLE;
        end else begin
          cnt_d = cnt_inc;
          if (reg_rd_valid) begin
            data_d  = reg_rd_data;
            err_d   = 1'b0;
            state_d = RESP;
          end else if (state_q == REQ) begin
            state_d = WAIT;
          end else if (cnt_inc >= TIMEOUT_C) begin
            // Valid is checked first, so a same-cycle valid beats timeout.
            data_d  = 32'd0;
            err_d   = 1'b1;
            state_d = RESP;
          end
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      idx_q   <= '0;
      data_q  <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  // Outputs depend only on registered state, never directly on PSEL.
  assign PREADY     = (state_q == RESP);
  assign PSLVERR    = (state_q == RESP) && err_q;
  assign PRDATA     = ((state_q == RESP) && !err_q) ? data_q : 32'd0;
  assign reg_rd_req = (state_q == REQ);
  assign reg_rd_idx = idx_q;

`ifdef RD_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (PSLVERR && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      err_cnt_q <= 8'd0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign rd_err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_apb_read_responder.sv
// -----------------------------------------------------------------------------
// tb_apb_read_responder
//
// Directed self-checking bench for apb_read_responder with default parameters
// (BASE_ADDR=0, NUM_REGS=16, TIMEOUT=10). Inputs change 1 time unit after the
// rising edge; outputs are checked at that same point, so each check sees the
// registered state produced by the preceding edge. "Cycle 0" is the cycle the
// setup phase is presented.
// -----------------------------------------------------------------------------
module tb_apb_read_responder;

  logic        PCLK;
  logic        PRESETn;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;
`ifdef RD_ERR_CNT_EN
  logic [7:0]  rd_err_count;
`endif
  logic        reg_rd_req;
  logic [3:0]  reg_rd_idx;
  logic        reg_rd_valid;
  logic [31:0] reg_rd_data;

  int errors = 0;
  int checks = 0;

  apb_read_responder #(
    .BASE_ADDR (32'h0000_0000),
    .NUM_REGS  (16),
    .TIMEOUT   (10)
  ) dut (
    .PCLK         (PCLK),
    .PRESETn      (PRESETn),
    .PSEL         (PSEL),
    .PENABLE      (PENABLE),
    .PWRITE       (PWRITE),
    .PADDR        (PADDR),
    .PRDATA       (PRDATA),
    .PREADY       (PREADY),
    .PSLVERR      (PSLVERR),
`ifdef RD_ERR_CNT_EN
    .rd_err_count (rd_err_count),
`endif
    .reg_rd_req   (reg_rd_req),
    .reg_rd_idx   (reg_rd_idx),
    .reg_rd_valid (reg_rd_valid),
    .reg_rd_data  (reg_rd_data)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // Advance one clock and settle just after the edge.
  task automatic cyc();
    @(posedge PCLK);
    #1;
  endtask

  task automatic idle_bus();
    PSEL         = 1'b0;
    PENABLE      = 1'b0;
    PWRITE       = 1'b0;
    PADDR        = 32'd0;
    reg_rd_valid = 1'b0;
    reg_rd_data  = 32'd0;
  endtask

  // Present a setup phase in cycle 0, then move to the access phase.
  task automatic setup(input logic [31:0] addr, input logic wr);
    PSEL    = 1'b1;
    PENABLE = 1'b0;
    PWRITE  = wr;
    PADDR   = addr;
    cyc();
    PENABLE = 1'b1;
  endtask

  task automatic do_reset();
    idle_bus();
    PRESETn = 1'b0;
    cyc();
    cyc();
    PRESETn = 1'b1;
    cyc();
  endtask

  task automatic test_reset();
    idle_bus();
    PRESETn = 1'b0;
    cyc();
    checks++; if (PREADY !== 1'b0) begin errors++; $display("FAIL reset_pready got=%b exp=0", PREADY); end
    checks++; if (PSLVERR !== 1'b0) begin errors++; $display("FAIL reset_pslverr got=%b exp=0", PSLVERR); end
    checks++; if (PRDATA !== 32'd0) begin errors++; $display("FAIL reset_prdata got=%h exp=0", PRDATA); end
    checks++; if (reg_rd_req !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", reg_rd_req); end
    checks++; if (reg_rd_idx !== 4'd0) begin errors++; $display("FAIL reset_idx got=%0d exp=0", reg_rd_idx); end
    PRESETn = 1'b1;
    cyc();
    $display("reset: outputs idle");
  endtask

  task automatic test_read_fast();
    setup(32'h08, 1'b0);
    // cycle 1: REQ
    checks++; if (reg_rd_req !== 1'b1) begin errors++; $display("FAIL fast_req got=%b exp=1", reg_rd_req); end
    checks++; if (reg_rd_idx !== 4'd2) begin errors++; $display("FAIL fast_idx got=%0d exp=2", reg_rd_idx); end
    checks++; if (PREADY !== 1'b0) begin errors++; $display("FAIL fast_pready_c1 got=%b exp=0", PREADY); end
    reg_rd_valid = 1'b1;
    reg_rd_data  = 32'hDEAD_BEEF;
    cyc();
    // cycle 2: RESP
    reg_rd_valid = 1'b0;
    checks++; if (PREADY !== 1'b1) begin errors++; $display("FAIL fast_pready_c2 got=%b exp=1", PREADY); end
    checks++; if (PRDATA !== 32'hDEAD_BEEF) begin errors++; $display("FAIL fast_prdata got=%h exp=deadbeef", PRDATA); end
    checks++; if (PSLVERR !== 1'b0) begin errors++; $display("FAIL fast_pslverr got=%b exp=0", PSLVERR); end
    checks++; if (reg_rd_req !== 1'b0) begin errors++; $display("FAIL fast_req_c2 got=%b exp=0", reg_rd_req); end
    PSEL = 1'b0; PENABLE = 1'b0;
    cyc();
    checks++; if (PREADY !== 1'b0) begin errors++; $display("FAIL fast_pready_c3 got=%b exp=0", PREADY); end
    $display("read 0x08: data=%h err=0", 32'hDEAD_BEEF);
  endtask

  task automatic test_read_wait();
    setup(32'h3C, 1'b0);
    checks++; if (reg_rd_req !== 1'b1) begin errors++; $display("FAIL wait_req got=%b exp=1", reg_rd_req); end
    checks++; if (reg_rd_idx !== 4'd15) begin errors++; $display("FAIL wait_idx got=%0d exp=15", reg_rd_idx); end
    // Four WAIT cycles (2..5) with no valid.
    for (int i = 0; i < 4; i++) begin
      cyc();
      checks++; if (PREADY !== 1'b0 || reg_rd_req !== 1'b0) begin errors++; $display("FAIL wait_hold%0d pready=%b req=%b exp=0/0", i, PREADY, reg_rd_req); end
    end
    cyc();
    // cycle 6: valid arrives
    reg_rd_valid = 1'b1;
    reg_rd_data  = 32'h1234_5678;
    checks++; if (reg_rd_idx !== 4'd15) begin errors++; $display("FAIL wait_idx_held got=%0d exp=15", reg_rd_idx); end
    cyc();
    // cycle 7: RESP
    reg_rd_valid = 1'b0;
    checks++; if (PREADY !== 1'b1) begin errors++; $display("FAIL wait_pready got=%b exp=1", PREADY); end
    checks++; if (PRDATA !== 32'h1234_5678) begin errors++; $display("FAIL wait_prdata got=%h exp=12345678", PRDATA); end
    checks++; if (PSLVERR !== 1'b0) begin errors++; $display("FAIL wait_pslverr got=%b exp=0", PSLVERR); end
    PSEL = 1'b0; PENABLE = 1'b0;
    cyc();
    checks++; if (PREADY !== 1'b0) begin errors++; $display("FAIL wait_pready_once got=%b exp=0", PREADY); end
    $display("read 0x3C: data=%h after 4 wait cycles", 32'h1234_5678);
  endtask

  task automatic test_timeout();
    int cyc_n;
    int late_req;
    setup(32'h04, 1'b0);
    // cycle 1 is REQ entry; response expected in cycle 11.
    cyc_n    = 1;
    late_req = 0;
    while (PREADY !== 1'b1 && cyc_n < 30) begin
      cyc();
      cyc_n++;
      if (PREADY !== 1'b1 && reg_rd_req === 1'b1) late_req++;
    end
    checks++; if (cyc_n !== 11) begin errors++; $display("FAIL timeout_cycle got=%0d exp=11", cyc_n); end
    checks++; if (PSLVERR !== 1'b1) begin errors++; $display("FAIL timeout_pslverr got=%b exp=1", PSLVERR); end
    checks++; if (PRDATA !== 32'd0) begin errors++; $display("FAIL timeout_prdata got=%h exp=0", PRDATA); end
    checks++; if (late_req !== 0) begin errors++; $display("FAIL timeout_extra_req got=%0d exp=0", late_req); end
    PSEL = 1'b0; PENABLE = 1'b0;
    // Late valid from the table must not produce anything.
    reg_rd_valid = 1'b1;
    reg_rd_data  = 32'hCAFE_F00D;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++; if (PREADY !== 1'b0 || PRDATA !== 32'd0) begin errors++; $display("FAIL timeout_late%0d pready=%b prdata=%h exp=0/0", i, PREADY, PRDATA); end
    end
    reg_rd_valid = 1'b0;
    $display("read 0x04: timeout err=1 in cycle %0d", cyc_n);
  endtask

  task automatic test_decode_err();
    logic [31:0] addrs [2];
    addrs[0] = 32'h06;
    addrs[1] = 32'h40;
    for (int i = 0; i < 2; i++) begin
      setup(addrs[i], 1'b0);
      checks++; if (PREADY !== 1'b1) begin errors++; $display("FAIL dec_pready addr=%h got=%b exp=1", addrs[i], PREADY); end
      checks++; if (PSLVERR !== 1'b1) begin errors++; $display("FAIL dec_pslverr addr=%h got=%b exp=1", addrs[i], PSLVERR); end
      checks++; if (PRDATA !== 32'd0) begin errors++; $display("FAIL dec_prdata addr=%h got=%h exp=0", addrs[i], PRDATA); end
      checks++; if (reg_rd_req !== 1'b0) begin errors++; $display("FAIL dec_req addr=%h got=%b exp=0", addrs[i], reg_rd_req); end
      PSEL = 1'b0; PENABLE = 1'b0;
      cyc();
      checks++; if (reg_rd_req !== 1'b0 || PREADY !== 1'b0) begin errors++; $display("FAIL dec_after addr=%h req=%b pready=%b exp=0/0", addrs[i], reg_rd_req, PREADY); end
      $display("read %h: decode error", addrs[i]);
    end
  endtask

  task automatic test_write_ignored();
    setup(32'h08, 1'b1);
    checks++; if (reg_rd_req !== 1'b0) begin errors++; $display("FAIL wr_req got=%b exp=0", reg_rd_req); end
    checks++; if (PREADY !== 1'b0) begin errors++; $display("FAIL wr_pready_c1 got=%b exp=0", PREADY); end
    cyc();
    checks++; if (PREADY !== 1'b0 || reg_rd_req !== 1'b0) begin errors++; $display("FAIL wr_c2 pready=%b req=%b exp=0/0", PREADY, reg_rd_req); end
    idle_bus();
    cyc();
    $display("write 0x08: ignored");
  endtask

  task automatic test_reset_mid();
    setup(32'h08, 1'b0);
    reg_rd_valid = 1'b0;
    reg_rd_data  = 32'hAAAA_5555;
    cyc();
    // cycle 2: WAIT; pulse reset.
    PRESETn = 1'b0;
    cyc();
    checks++; if (PREADY !== 1'b0 || PSLVERR !== 1'b0 || PRDATA !== 32'd0) begin errors++; $display("FAIL rstmid_resp pready=%b pslverr=%b prdata=%h exp=0/0/0", PREADY, PSLVERR, PRDATA); end
    checks++; if (reg_rd_req !== 1'b0 || reg_rd_idx !== 4'd0) begin errors++; $display("FAIL rstmid_req req=%b idx=%0d exp=0/0", reg_rd_req, reg_rd_idx); end
    PRESETn      = 1'b1;
    reg_rd_valid = 1'b1;
    cyc();
    checks++; if (PREADY !== 1'b0) begin errors++; $display("FAIL rstmid_noresp got=%b exp=0", PREADY); end
    idle_bus();
    cyc();
    $display("reset during wait: aborted");
  endtask

  task automatic test_abort();
    setup(32'h0C, 1'b0);
    cyc();
    // WAIT; master drops PSEL, then the table answers.
    PSEL = 1'b0; PENABLE = 1'b0;
    cyc();
    reg_rd_valid = 1'b1;
    reg_rd_data  = 32'h5A5A_5A5A;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++; if (PREADY !== 1'b0) begin errors++; $display("FAIL abort_pready%0d got=%b exp=0", i, PREADY); end
    end
    reg_rd_valid = 1'b0;
    $display("read 0x0C: master abort");
  endtask

  task automatic test_back_to_back();
    setup(32'h00, 1'b0);
    reg_rd_valid = 1'b1;
    reg_rd_data  = 32'h1111_1111;
    cyc();
    reg_rd_valid = 1'b0;
    checks++; if (PREADY !== 1'b1 || PRDATA !== 32'h1111_1111) begin errors++; $display("FAIL b2b_first pready=%b prdata=%h exp=1/11111111", PREADY, PRDATA); end
    PSEL = 1'b0; PENABLE = 1'b0;
    cyc();
    // IDLE again: next setup right away.
    setup(32'h10, 1'b0);
    checks++; if (reg_rd_req !== 1'b1 || reg_rd_idx !== 4'd4) begin errors++; $display("FAIL b2b_req req=%b idx=%0d exp=1/4", reg_rd_req, reg_rd_idx); end
    reg_rd_valid = 1'b1;
    reg_rd_data  = 32'h2222_2222;
    cyc();
    reg_rd_valid = 1'b0;
    checks++; if (PREADY !== 1'b1 || PRDATA !== 32'h2222_2222) begin errors++; $display("FAIL b2b_second pready=%b prdata=%h exp=1/22222222", PREADY, PRDATA); end
    PSEL = 1'b0; PENABLE = 1'b0;
    cyc();
    $display("back-to-back: 0x00=%h 0x10=%h", 32'h1111_1111, 32'h2222_2222);
  endtask

`ifdef RD_ERR_CNT_EN
  task automatic test_err_count();
    do_reset();
    checks++; if (rd_err_count !== 8'd0) begin errors++; $display("FAIL errcnt_reset got=%0d exp=0", rd_err_count); end
    for (int t = 0; t < 3; t++) begin
      setup(32'h04, 1'b0);
      for (int k = 0; k < 30 && PREADY !== 1'b1; k++) cyc();
      PSEL = 1'b0; PENABLE = 1'b0;
      cyc();
    end
    setup(32'h08, 1'b0);
    reg_rd_valid = 1'b1;
    reg_rd_data  = 32'h0BAD_F00D;
    cyc();
    reg_rd_valid = 1'b0;
    PSEL = 1'b0; PENABLE = 1'b0;
    cyc();
    checks++; if (rd_err_count !== 8'd3) begin errors++; $display("FAIL errcnt_three got=%0d exp=3", rd_err_count); end
    for (int n = 0; n < 300; n++) begin
      setup(32'h40, 1'b0);
      PSEL = 1'b0; PENABLE = 1'b0;
      cyc();
    end
    checks++; if (rd_err_count !== 8'd255) begin errors++; $display("FAIL errcnt_sat got=%0d exp=255", rd_err_count); end
    $display("error counter: saturated at %0d", 255);
  endtask
`endif

  initial begin
    idle_bus();
    PRESETn = 1'b0;
    test_reset();
    test_read_fast();
    test_read_wait();
    test_timeout();
    test_decode_err();
    test_write_ignored();
    test_reset_mid();
    test_abort();
    test_back_to_back();
`ifdef RD_ERR_CNT_EN
    test_err_count();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
